// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for a single sp_ram-style slave port.
// The granted request is registered onto the slave port; a watchdog forces completion if the slave never acks.
module bus_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,

    input  logic            i_m0_bus_en,
    input  logic            i_m0_wr_en,
    input  logic [AW-1:0]   i_m0_addr,
    input  logic [DW-1:0]   i_m0_wr_data,
    input  logic [DW/8-1:0] i_m0_byte_en,
    output logic            o_m0_ack,
    output logic [DW-1:0]   o_m0_rd_data,
    output logic            o_m0_err,

    input  logic            i_m1_bus_en,
    input  logic            i_m1_wr_en,
    input  logic [AW-1:0]   i_m1_addr,
    input  logic [DW-1:0]   i_m1_wr_data,
    input  logic [DW/8-1:0] i_m1_byte_en,
    output logic            o_m1_ack,
    output logic [DW-1:0]   o_m1_rd_data,
    output logic            o_m1_err,

    output logic            o_s_cs,
    output logic            o_s_wr_en,
    output logic [AW-1:0]   o_s_addr,
    output logic [DW-1:0]   o_s_wr_data,
    output logic [DW/8-1:0] o_s_byte_en,
    input  logic            i_s_ack,
    input  logic [DW-1:0]   i_s_rd_data,

    output logic            o_grant
);

    localparam int BW = DW / 8;
    localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            grant_q, grant_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic            s_cs_q, s_cs_d;
    logic            s_wr_en_q, s_wr_en_d;
    logic [AW-1:0]   s_addr_q, s_addr_d;
    logic [DW-1:0]   s_wr_data_q, s_wr_data_d;
    logic [BW-1:0]   s_byte_en_q, s_byte_en_d;

    logic            pick;
    logic            wd_hit;
    logic            done;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        wdog_d       = wdog_q;
        s_cs_d       = s_cs_q;
        s_wr_en_d    = s_wr_en_q;
        s_addr_d     = s_addr_q;
        s_wr_data_d  = s_wr_data_q;
        s_byte_en_d  = s_byte_en_q;
        pick         = 1'b0;
        wd_hit       = (wdog_q == WD_LIMIT);
        done         = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_m0_bus_en || i_m1_bus_en) begin
                    // On a tie the master that was not served last wins.
                    pick        = (i_m0_bus_en && (!i_m1_bus_en || last_grant_q)) ? 1'b0 : 1'b1;
                    grant_d     = pick;
                    s_cs_d      = 1'b1;
                    wdog_d      = '0;
                    s_wr_en_d   = pick ? i_m1_wr_en   : i_m0_wr_en;
                    s_addr_d    = pick ? i_m1_addr    : i_m0_addr;
                    s_wr_data_d = pick ? i_m1_wr_data : i_m0_wr_data;
                    s_byte_en_d = pick ? i_m1_byte_en : i_m0_byte_en;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                done = i_s_ack || wd_hit;
                if (done) begin
                    last_grant_d = grant_q;
                    s_cs_d       = 1'b0;
                    state_d      = IDLE;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            wdog_q       <= '0;
            s_cs_q       <= 1'b0;
            s_wr_en_q    <= 1'b0;
            s_addr_q     <= '0;
            s_wr_data_q  <= '0;
            s_byte_en_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            wdog_q       <= wdog_d;
            s_cs_q       <= s_cs_d;
            s_wr_en_q    <= s_wr_en_d;
            s_addr_q     <= s_addr_d;
            s_wr_data_q  <= s_wr_data_d;
            s_byte_en_q  <= s_byte_en_d;
        end
    end

    // A completion landing in a reset cycle is suppressed so no ack escapes.
    logic ack_any;
    assign ack_any = done && !i_rst;

    assign o_m0_ack     = ack_any && !grant_q;
    assign o_m1_ack     = ack_any &&  grant_q;
    assign o_m0_err     = o_m0_ack && !i_s_ack;
    assign o_m1_err     = o_m1_ack && !i_s_ack;
    assign o_m0_rd_data = (o_m0_ack && i_s_ack) ? i_s_rd_data : '0;
    assign o_m1_rd_data = (o_m1_ack && i_s_ack) ? i_s_rd_data : '0;

    assign o_s_cs      = s_cs_q;
    assign o_s_wr_en   = s_wr_en_q;
    assign o_s_addr    = s_addr_q;
    assign o_s_wr_data = s_wr_data_q;
    assign o_s_byte_en = s_byte_en_q;
    assign o_grant     = grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with TIMEOUT=8.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_en, m0_we, m1_en, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wd, m1_wd;
    logic [3:0]    m0_be, m1_be;
    logic          m0_ack, m1_ack, m0_err, m1_err;
    logic [DW-1:0] m0_rd, m1_rd;
    logic          s_cs, s_we, s_ack;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wd, s_rd;
    logic [3:0]    s_be;
    logic          grant;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT(8), .AW(AW), .DW(DW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m0_bus_en(m0_en), .i_m0_wr_en(m0_we), .i_m0_addr(m0_addr),
        .i_m0_wr_data(m0_wd), .i_m0_byte_en(m0_be),
        .o_m0_ack(m0_ack), .o_m0_rd_data(m0_rd), .o_m0_err(m0_err),
        .i_m1_bus_en(m1_en), .i_m1_wr_en(m1_we), .i_m1_addr(m1_addr),
        .i_m1_wr_data(m1_wd), .i_m1_byte_en(m1_be),
        .o_m1_ack(m1_ack), .o_m1_rd_data(m1_rd), .o_m1_err(m1_err),
        .o_s_cs(s_cs), .o_s_wr_en(s_we), .o_s_addr(s_addr),
        .o_s_wr_data(s_wd), .o_s_byte_en(s_be),
        .i_s_ack(s_ack), .i_s_rd_data(s_rd),
        .o_grant(grant)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m0_en = 0; m0_we = 0; m0_addr = '0; m0_wd = '0; m0_be = '0;
        m1_en = 0; m1_we = 0; m1_addr = '0; m1_wd = '0; m1_be = '0;
        s_ack = 0; s_rd = '0;
        do_reset();

        // Reset state
        settle();
        chk("rst_cs", s_cs, 0);
        chk("rst_grant", grant, 0);
        chk("rst_addr", s_addr, 0);
        chk("rst_m0_ack", m0_ack, 0);
        chk("rst_m1_ack", m1_ack, 0);

        // Single zero-wait read from M0
        m0_en = 1; m0_addr = 32'h8000_0010;
        settle();
        chk("t1_cs_before", s_cs, 0);
        tick();
        chk("t1_cs", s_cs, 1);
        chk("t1_addr", s_addr, 32'h8000_0010);
        chk("t1_we", s_we, 0);
        s_ack = 1; s_rd = 32'hDEAD_BEEF;
        settle();
        chk("t1_m0_ack", m0_ack, 1);
        chk("t1_m0_rd", m0_rd, 32'hDEAD_BEEF);
        chk("t1_m0_err", m0_err, 0);
        chk("t1_m1_ack", m1_ack, 0);
        chk("t1_m1_rd", m1_rd, 0);
        tick();
        m0_en = 0;
        settle();
        chk("t1_cs_after", s_cs, 0);
        chk("t1_idle_ack_ignored", m0_ack, 0);
        tick();
        s_ack = 0;
        settle();
        chk("t1_idle_stays", s_cs, 0);

        // Simultaneous continuous requests from reset alternate 0,1,0,1,0,1
        do_reset();
        m0_en = 1; m0_addr = 32'h100; m1_en = 1; m1_addr = 32'h200;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t2_grant", grant, i % 2);
            chk("t2_addr", s_addr, (i % 2) ? 32'h200 : 32'h100);
            s_ack = 1; s_rd = 32'hA0 + i;
            settle();
            chk("t2_m0_ack", m0_ack, (i % 2) == 0);
            chk("t2_m1_ack", m1_ack, (i % 2) == 1);
            tick();
            s_ack = 0;
            settle();
            chk("t2_gap_cs", s_cs, 0);
        end
        m0_en = 0; m1_en = 0;
        tick();

        // Write forwarding from M1, fields frozen after grant
        m1_en = 1; m1_we = 1; m1_addr = 32'h8000_1000; m1_wd = 32'h1234_5678; m1_be = 4'b0011;
        tick();
        chk("t3_grant", grant, 1);
        chk("t3_we", s_we, 1);
        chk("t3_addr", s_addr, 32'h8000_1000);
        chk("t3_wd", s_wd, 32'h1234_5678);
        chk("t3_be", s_be, 4'b0011);
        m1_we = 0; m1_addr = 32'h0; m1_wd = 32'hFFFF_FFFF; m1_be = 4'b1111;
        tick();
        chk("t3_frz_we", s_we, 1);
        chk("t3_frz_addr", s_addr, 32'h8000_1000);
        chk("t3_frz_wd", s_wd, 32'h1234_5678);
        chk("t3_frz_be", s_be, 4'b0011);
        chk("t3_no_ack", m1_ack, 0);
        s_ack = 1; s_rd = '0;
        settle();
        chk("t3_m1_ack", m1_ack, 1);
        chk("t3_m0_ack", m0_ack, 0);
        tick();
        s_ack = 0; m1_en = 0;

        // Three wait states on M0 while M1 queues
        m0_en = 1; m0_we = 0; m0_addr = 32'h300;
        tick();
        chk("t4_grant", grant, 0);
        m1_en = 1; m1_we = 0; m1_addr = 32'h400;
        for (int w = 0; w < 3; w++) begin
            settle();
            chk("t4_wait_cs", s_cs, 1);
            chk("t4_wait_m0", m0_ack, 0);
            chk("t4_wait_m1", m1_ack, 0);
            tick();
        end
        s_ack = 1; s_rd = 32'h5555_AAAA;
        settle();
        chk("t4_cs4", s_cs, 1);
        chk("t4_m0_ack", m0_ack, 1);
        chk("t4_m0_rd", m0_rd, 32'h5555_AAAA);
        chk("t4_m1_ack", m1_ack, 0);
        tick();
        s_ack = 0; m0_en = 0;
        settle();
        chk("t4_cs_off", s_cs, 0);
        chk("t4_m1_wait", m1_ack, 0);
        tick();
        chk("t4_m1_grant", grant, 1);
        chk("t4_m1_addr", s_addr, 32'h400);
        s_ack = 1;
        settle();
        chk("t4_m1_ack", m1_ack, 1);
        tick();
        s_ack = 0; m1_en = 0;

        // Watchdog: slave never acks M0; M1 pending
        m0_en = 1; m0_addr = 32'hBAD0_0000; s_rd = 32'hCAFE_F00D;
        tick();
        m1_en = 1; m1_addr = 32'h500;
        for (int j = 0; j < 8; j++) begin
            settle();
            chk("t5_cs", s_cs, 1);
            chk("t5_no_ack", m0_ack, 0);
            tick();
        end
        chk("t5_m0_ack", m0_ack, 1);
        chk("t5_m0_err", m0_err, 1);
        chk("t5_m0_rd", m0_rd, 0);
        chk("t5_m1_ack", m1_ack, 0);
        tick();
        m0_en = 0;
        chk("t5_cs_off", s_cs, 0);
        tick();
        chk("t5_m1_grant", grant, 1);
        chk("t5_m1_cs", s_cs, 1);
        s_ack = 1;
        settle();
        chk("t5_m1_ack", m1_ack, 1);
        chk("t5_m1_err", m1_err, 0);
        tick();
        s_ack = 0; m1_en = 0;

        // Reset during a wait-stated M1 read restores the M0 tie preference
        m0_en = 1; m0_addr = 32'h600;
        tick();
        s_ack = 1;
        settle();
        chk("t6_m0_ack", m0_ack, 1);
        tick();
        s_ack = 0; m0_en = 0;
        m1_en = 1; m1_addr = 32'h700;
        tick();
        chk("t6_m1_grant", grant, 1);
        tick();
        rst = 1; s_ack = 1;
        settle();
        chk("t6_rst_no_ack", m1_ack, 0);
        tick();
        rst = 0; s_ack = 0; m1_en = 0;
        settle();
        chk("t6_cs_cleared", s_cs, 0);
        chk("t6_no_ack_after", m1_ack, 0);
        m0_en = 1; m1_en = 1;
        tick();
        chk("t6_tie_m0", grant, 0);
        chk("t6_tie_addr", s_addr, 32'h600);
        s_ack = 1;
        settle();
        chk("t6_tie_ack", m0_ack, 1);
        tick();
        s_ack = 0; m0_en = 0; m1_en = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout_guard observed=running expected=finished");
        $fatal(1, "bench time limit expired");
    end

endmodule
